// File: rtl/osc_tick_pkg.sv
// Shared constants, types and helpers for the oscillator tick generator.
// Channel operating modes are classified once per cycle and drive the update rules.
package osc_tick_pkg;

    localparam int CLK_HZ        = 12_000_000;
    localparam int DEFAULT_CNT_W = 24;

    typedef logic [DEFAULT_CNT_W-1:0] div_t;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_COUNT = 2'd1,
        CH_SYNC  = 2'd2
    } ch_mode_e;

    function automatic div_t hz_to_div(input int hz);
        return div_t'(CLK_HZ / hz);
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick/square-wave channel: up-counter, active period, shadow period,
// pending flag and registered tick/sq outputs.
module tick_channel
    import osc_tick_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int DEFAULT_DIV = CLK_HZ
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    input  logic             sync,
    output logic             tick,
    output logic             sq,
    output logic             pending
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    ch_mode_e         mode;
    logic             wrap;

    always_comb begin
        if (sync) begin
            mode = CH_SYNC;
        end else if (en && (active_q != '0)) begin
            mode = CH_COUNT;
        end else begin
            mode = CH_IDLE;
        end
    end

    // Only meaningful in CH_COUNT, where active_q >= 1 keeps the subtraction in range.
    assign wrap = (cnt_q == (active_q - CNT_ONE));

    always_comb begin
        cnt_d     = cnt_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        tick_d    = 1'b0;
        sq_d      = sq_q;
        case (mode)
            CH_SYNC: begin
                cnt_d     = '0;
                sq_d      = 1'b0;
                pending_d = 1'b0;
                if (div_load) begin
                    active_d = div_val;
                end else if (pending_q) begin
                    active_d = shadow_q;
                end
            end
            CH_COUNT: begin
                if (wrap) begin
                    cnt_d     = '0;
                    tick_d    = 1'b1;
                    sq_d      = ~sq_q;
                    pending_d = 1'b0;
                    if (div_load) begin
                        active_d = div_val;
                    end else if (pending_q) begin
                        active_d = shadow_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (div_load) begin
                        shadow_d  = div_val;
                        pending_d = 1'b1;
                    end
                end
            end
            default: begin
                // Not counting: loads take effect at once and restart the period.
                if (div_load) begin
                    active_d  = div_val;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                end else if (active_q == '0) begin
                    cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            active_q  <= DIV_RST;
            shadow_q  <= DIV_RST;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
            sq_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            sq_q      <= sq_d;
        end
    end

    assign tick    = tick_q;
    assign sq      = sq_q;
    assign pending = pending_q;

endmodule

// File: rtl/osc_tick_gen.sv
// Multichannel programmable tick and square-wave generator; channels are
// independent except for the shared phase-restart sync.
module osc_tick_gen
    import osc_tick_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int DEFAULT_DIV = int'(hz_to_div(1))
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*CNT_W-1:0] div_val,
    input  logic [NUM_CH-1:0]       div_load,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       sq,
    output logic [NUM_CH-1:0]       pending
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .en       (en[g]),
            .div_val  (div_val[g*CNT_W +: CNT_W]),
            .div_load (div_load[g]),
            .sync     (sync),
            .tick     (tick[g]),
            .sq       (sq[g]),
            .pending  (pending[g])
        );
    end

endmodule

// File: tb/tb_osc_tick_gen.sv
// Bench for osc_tick_gen: remaining-edges model compared every cycle, plus
// directed scenarios with hand-computed tick/sq/pending expectations.
module tb_osc_tick_gen;

    localparam int NUM_CH      = 2;
    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 4;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [1:0]  en       = 2'b00;
    logic [15:0] div_val  = '0;
    logic [1:0]  div_load = 2'b00;
    logic        sync     = 1'b0;
    logic [1:0]  tick, sq, pending;

    int checks = 0;
    int errors = 0;

    osc_tick_gen #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .sync     (sync),
        .tick     (tick),
        .sq       (sq),
        .pending  (pending)
    );

    always #42 clk = ~clk;

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: per channel, the number of enabled edges still to go before the next tick.
    int         m_per[2];
    int         m_rem[2];
    int         m_shd[2];
    logic [1:0] m_tick, m_sq, m_pend;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_per[i] = DEFAULT_DIV; m_rem[i] = DEFAULT_DIV; m_shd[i] = DEFAULT_DIV;
                m_tick[i] = 1'b0; m_sq[i] = 1'b0; m_pend[i] = 1'b0;
            end else if (sync) begin
                if (div_load[i]) m_per[i] = int'(div_val[i*8 +: 8]);
                else if (m_pend[i]) m_per[i] = m_shd[i];
                m_pend[i] = 1'b0; m_rem[i] = m_per[i]; m_tick[i] = 1'b0; m_sq[i] = 1'b0;
            end else if (!en[i] || m_per[i] == 0) begin
                m_tick[i] = 1'b0;
                if (div_load[i]) begin
                    m_per[i] = int'(div_val[i*8 +: 8]); m_rem[i] = m_per[i]; m_pend[i] = 1'b0;
                end
            end else begin
                m_rem[i] = m_rem[i] - 1;
                if (m_rem[i] == 0) begin
                    m_tick[i] = 1'b1; m_sq[i] = ~m_sq[i];
                    if (div_load[i]) m_per[i] = int'(div_val[i*8 +: 8]);
                    else if (m_pend[i]) m_per[i] = m_shd[i];
                    m_pend[i] = 1'b0; m_rem[i] = m_per[i];
                end else begin
                    m_tick[i] = 1'b0;
                    if (div_load[i]) begin
                        m_shd[i] = int'(div_val[i*8 +: 8]); m_pend[i] = 1'b1;
                    end
                end
            end
        end
        #1;
        if (reset) begin
            chk("model_tick", tick, m_tick);
            chk("model_sq", sq, m_sq);
            chk("model_pending", pending, m_pend);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset pulse; released on a negedge so the next posedge is cycle 1.
    task automatic restart(input logic [1:0] e);
        div_load = 2'b00; sync = 1'b0; en = e;
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    task automatic load(input int ch, input int v);
        div_val[ch*8 +: 8] = 8'(v);
        div_load[ch] = 1'b1;
        step(1);
        div_load = 2'b00;
    endtask

    initial begin
        #5;
        // Default period 4 on both channels
        restart(2'b11);
        for (int c = 1; c <= 12; c++) begin
            step(1);
            chk("s1_tick", tick, (c % 4 == 0) ? 2'b11 : 2'b00);
            chk("s1_sq", sq, ((c / 4) % 2 == 1) ? 2'b11 : 2'b00);
            chk("s1_pending", pending, 2'b00);
        end

        // Shadowed load of 6 on channel 0 at cycle 5
        restart(2'b11);
        step(5);
        load(0, 6);
        chk("s2_pend6", pending, 2'b01);
        step(1);
        chk("s2_pend7", pending, 2'b01);
        step(1);
        chk("s2_tick8", tick, 2'b11);
        chk("s2_pend8", pending, 2'b00);
        for (int c = 9; c <= 20; c++) begin
            step(1);
            chk("s2_tick", tick, {c % 4 == 0, c == 14 || c == 20});
        end

        // Two loads before the wrap: last one wins
        restart(2'b01);
        step(1);
        load(0, 10);
        load(0, 3);
        chk("s3_pend3", pending, 2'b01);
        step(1);
        chk("s3_tick4", tick, 2'b01);
        chk("s3_pend4", pending, 2'b00);
        for (int c = 5; c <= 14; c++) begin
            step(1);
            chk("s3_tick", tick, {1'b0, c == 7 || c == 10 || c == 13});
        end

        // Channel 1 disabled at cnt=2 for five edges
        restart(2'b11);
        step(2);
        en = 2'b01;
        for (int c = 3; c <= 7; c++) begin
            step(1);
            chk("s4_tick_off", tick, {1'b0, c == 4});
            chk("s4_sq_off", sq, {1'b0, c >= 4});
        end
        en = 2'b11;
        step(1);
        chk("s4_tick8", tick, 2'b01);
        chk("s4_sq8", sq, 2'b00);
        step(1);
        chk("s4_tick9", tick, 2'b10);
        chk("s4_sq9", sq, 2'b10);

        // Period 0 idles channel 0; then period 1 gives constant tick
        restart(2'b00);
        load(0, 0);
        en = 2'b11;
        for (int c = 2; c <= 51; c++) begin
            step(1);
            chk("s5_idle_tick", tick, {(c - 1) % 4 == 0, 1'b0});
            chk("s5_idle_sq0", {1'b0, sq[0]}, 2'b00);
        end
        load(0, 1);
        chk("s5_tick52", {1'b0, tick[0]}, 2'b00);
        for (int c = 53; c <= 58; c++) begin
            step(1);
            chk("s5_div1_tick", {1'b0, tick[0]}, 2'b01);
            chk("s5_div1_sq", {1'b0, sq[0]}, {1'b0, (c - 52) % 2 == 1});
        end

        // Sync with a pending load of 5, then reset mid-period
        restart(2'b11);
        step(1);
        load(0, 5);
        chk("s6_pend2", pending, 2'b01);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        chk("s6_sync_tick", tick, 2'b00);
        chk("s6_sync_sq", sq, 2'b00);
        chk("s6_sync_pend", pending, 2'b00);
        for (int c = 4; c <= 8; c++) begin
            step(1);
            chk("s6_tick", tick, {c == 7, c == 8});
        end
        chk("s6_sq8", sq, 2'b11);
        load(1, 9);
        chk("s6_pend9", pending, 2'b10);
        reset = 1'b0;
        #1;
        chk("s6_rst_tick", tick, 2'b00);
        chk("s6_rst_sq", sq, 2'b00);
        chk("s6_rst_pend", pending, 2'b00);
        step(2);
        en = 2'b11;
        reset = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step(1);
            chk("s6_post_tick", tick, (c == 4) ? 2'b11 : 2'b00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
